// File: rtl/lmfe_median_unit_if.sv
// Update/result bundle between the filter controller (master) and lmfe_median_unit (slave).
interface lmfe_median_unit_if #(
   parameter int unsigned W = 8
);
   logic         CLR;
   logic         SE;
   logic [W-1:0] INS;
   logic [W-1:0] DEL;
   logic [W-1:0] MED;
   logic         VLD;
   logic         ERR;

   modport master (output CLR, SE, INS, DEL, input MED, VLD, ERR);
   modport slave  (input CLR, SE, INS, DEL, output MED, VLD, ERR);
endinterface

// File: rtl/lmfe_median_unit.sv
// Running median over an N-sample window held as a sorted register array, one insert+delete per cycle.
// Optional macro LMFE_MED_CHECK_EN enables the sticky delete-miss flag on ERR.
module lmfe_median_unit #(
   parameter int unsigned N = 49,
   parameter int unsigned W = 8
) (
   input  logic              clk,
   input  logic              RST_N,
   lmfe_median_unit_if.slave bus
);
   localparam int unsigned CW  = $clog2(N + 1);
   localparam int unsigned MID = (N - 1) / 2;

   logic [W-1:0]  slot_q [N];
   logic [W-1:0]  slot_d [N];
   logic [W-1:0]  rem    [N];
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [W-1:0]  med_q;
   logic          vld_q;
   logic          full;
   logic          hit;
   int unsigned   r_idx;
   int unsigned   p_idx;
   int unsigned   k;
   int unsigned   j;

   always_comb begin
      full  = (cnt_q == CW'(N));
      hit   = 1'b0;
      r_idx = N - 1;
      p_idx = 0;
      k     = 0;
      j     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!hit && slot_q[i] == bus.DEL) begin
            hit   = 1'b1;
            r_idx = i;
         end
      end
      // While filling the delete always drops the top padding slot
      if (!full) r_idx = N - 1;
      for (int unsigned i = 0; i < N; i++) begin
         k = (i + 1 < N) ? i + 1 : N - 1;
         if (i < r_idx)      rem[i] = slot_q[i];
         else if (i + 1 < N) rem[i] = slot_q[k];
         else                rem[i] = '1;
      end
      for (int unsigned i = 0; i + 1 < N; i++) begin
         if (rem[i] < bus.INS) p_idx = p_idx + 1;
      end
      for (int unsigned i = 0; i < N; i++) begin
         j = (i == 0) ? 0 : i - 1;
         if (i < p_idx)       slot_d[i] = rem[i];
         else if (i == p_idx) slot_d[i] = bus.INS;
         else                 slot_d[i] = rem[j];
      end
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         slot_q <= '{default: '1};
         cnt_q  <= '0;
         med_q  <= '1;
         vld_q  <= 1'b0;
      end else if (bus.CLR) begin
         slot_q <= '{default: '1};
         cnt_q  <= '0;
         med_q  <= '1;
         vld_q  <= 1'b0;
      end else if (!bus.SE) begin
         slot_q <= slot_d;
         cnt_q  <= cnt_d;
         med_q  <= slot_d[MID];
         vld_q  <= (cnt_d == CW'(N));
      end
   end

   assign bus.MED = med_q;
   assign bus.VLD = vld_q;

`ifdef LMFE_MED_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)                    err_q <= 1'b0;
      else if (bus.CLR)              err_q <= 1'b0;
      else if (!bus.SE && full && !hit) err_q <= 1'b1;
   end

   assign bus.ERR = err_q;
`else
   assign bus.ERR = 1'b0;
`endif

endmodule
